i2c_image_loader: RTL
=====================

Name: i2c_image_loader

Overview:
- Upstream sequencer for one I2C EEPROM master (I2C_inst_com or I2C_data_com instance, selected by DATA_W).
- Walks an on-chip image table of (address, data) pairs and issues one write command per entry, waiting for Done_Sig each time.
- Optionally reads every entry back and compares it against the table.
- On success, releases bus ownership (IICING low) and asserts Core_EN so CarbonCore can run.
- Replaces the bench-only load loop for on-FPGA bring-up.

Parameters:
DATA_W, 16, word width of WrData/RdData (16 inst memory, 8 data memory)
ADDR_W, 8, EEPROM word address width
COUNT, 8, number of image entries loaded (1..2**IDX_W)
IDX_W, 4, image table index width
GAP, 2, idle cycles with Start_Sig=00 after each Done_Sig

Ports:
CLK  input  1  system clock
RSTn  input  1  synchronous active-low reset
Go  input  1  rising-edge request to start a load; ignored while Busy
Img_Idx  output  IDX_W  image table index; table is a synchronous ROM, data valid 1 cycle after index
Img_Addr  input  ADDR_W  EEPROM address of entry Img_Idx
Img_Data  input  DATA_W  word of entry Img_Idx
Start_Sig  output  2  to I2C master: 01 write, 10 read, 00 idle
Addr_Sig  output  ADDR_W  to I2C master word address
WrData  output  DATA_W  to I2C master write data
RdData  input  DATA_W  from I2C master read data, valid when Done_Sig is seen
Done_Sig  input  1  from I2C master: command finished (may be a pulse or a level)
Busy  output  1  high from accepted Go until DONE/ERR
IICING  output  1  bus-ownership flag to Top; high while Busy
Core_EN  output  1  level high after a successful load until next Go or reset
Load_Err  output  1  sticky verify mismatch flag
Err_Idx  output  IDX_W  index of first mismatching entry

Behaviour:
- Reset (RSTn=0 at posedge CLK), all outputs 0:
  - state IDLE; Start_Sig=00; Addr_Sig=0; WrData=0; Img_Idx=0; Busy=0; IICING=0; Core_EN=0; Load_Err=0; Err_Idx=0.
  - Reset mid-command drops Start_Sig to 00 in the same edge and abandons the sequence.
- Go edge detect: Go registered; start on Go=1 and Go_q=0 only in IDLE, DONE or ERR.
  - Start clears Core_EN, Load_Err and Err_Idx, sets Img_Idx=0, Busy=1 and IICING=1.
- States:
  - IDLE -> W_FETCH on start.
  - W_FETCH: one cycle for ROM latency; then latch Addr_Sig=Img_Addr, WrData=Img_Data -> W_REQ.
  - W_REQ: Start_Sig=01 held steady, Addr_Sig/WrData stable; on Done_Sig=1 -> W_GAP.
  - W_GAP: Start_Sig=00 for GAP cycles.
    - If Done_Sig is still 1 after GAP, stay until it drops, so a level Done is not double-counted.
    - Then, if Img_Idx==COUNT-1: Img_Idx=0 -> R_FETCH (or DONE when VERIFY_EN is undefined).
    - Else Img_Idx+1 -> W_FETCH.
  - R_FETCH: one cycle; latch Addr_Sig=Img_Addr -> R_REQ.
  - R_REQ: Start_Sig=10; on Done_Sig=1 capture RdData.
    - Captured value != Img_Data (held for the current index): set Load_Err, Err_Idx=Img_Idx, -> ERR.
    - Otherwise -> R_GAP.
  - R_GAP: same GAP and Done-drop rule; last index -> DONE, else Img_Idx+1 -> R_FETCH.
  - DONE: Start_Sig=00, Busy=0, IICING=0, Core_EN=1 (registered, asserted the cycle DONE is entered).
  - ERR: Start_Sig=00, Busy=0, IICING stays 1 (core kept off the bus), Core_EN=0.
- Start_Sig changes only on state transitions; never goes directly 01<->10 without at least GAP cycles of 00.
- Index wrap: Img_Idx never exceeds COUNT-1; COUNT=2**IDX_W is legal, with the last index all-ones.
- Done_Sig asserted while not in W_REQ/R_REQ is ignored.
- No timeout: a missing Done_Sig holds the FSM in the REQ state with Busy=1.

Optional Feature:
VERIFY_EN
- Defined: read-back/compare phase (R_FETCH, R_REQ, R_GAP, ERR) is compiled in; Load_Err and Err_Idx are functional.
- Undefined: after the last write the FSM goes W_GAP -> DONE; Start_Sig never takes 10; Load_Err and Err_Idx are tied to 0; RdData is unused.

Test Plan:
- Reset mid-write: RSTn=0 in W_REQ -> next edge Start_Sig=00, Busy=0, IICING=0; no further commands after release.
- Normal load, COUNT=8, table addr 00..07 / data 1000..1007, behavioural EEPROM slave with 1-cycle Done pulse:
  - Exactly 8 writes (Start=01, each with matching Addr_Sig/WrData), then 8 reads (Start=10).
  - Finally Core_EN=1, IICING=0, Load_Err=0.
- Corrupt slave word at addr 05 (returns 1FFF) -> Load_Err=1, Err_Idx=5, Core_EN=0, IICING=1, no read of index 6 issued.
- Level Done_Sig held 10 cycles, GAP=2 -> each entry issued exactly once; Start_Sig 00 for ≥10 cycles between commands.
- Go pulsed while Busy -> ignored, command count unchanged; Go after DONE -> Core_EN drops, full reload of 8 writes repeats.
- Compile without VERIFY_EN -> Start_Sig never 10; Core_EN=1 one cycle after the 8th write's GAP completes.

Source files
------------

// File: rtl/i2c_image_loader.sv
// i2c_image_loader: walks an (address, data) image table and writes each entry through one I2C
// EEPROM master. Define VERIFY_EN to add a read-back/compare pass before Core_EN is granted.
module i2c_image_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int COUNT  = 8,
  parameter int IDX_W  = 4,
  parameter int GAP    = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Go,
  output logic [IDX_W-1:0]  Img_Idx,
  input  logic [ADDR_W-1:0] Img_Addr,
  input  logic [DATA_W-1:0] Img_Data,
  output logic [1:0]        Start_Sig,
  output logic [ADDR_W-1:0] Addr_Sig,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  input  logic              Done_Sig,
  output logic              Busy,
  output logic              IICING,
  output logic              Core_EN,
  output logic              Load_Err,
  output logic [IDX_W-1:0]  Err_Idx
);

  localparam int               GAP_W    = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'((GAP < 1) ? 0 : GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  typedef enum logic [3:0] {
    IDLE, W_FETCH, W_REQ, W_GAP, R_FETCH, R_REQ, R_GAP, DONE, ERR
  } state_t;

  state_t           state;
  logic             go_q;
  logic             fetch_wait;
  logic [GAP_W-1:0] gap_cnt;
  logic             start_req;
  logic             gap_done;
  logic             last_idx;

  assign start_req = Go && !go_q && (state == IDLE || state == DONE || state == ERR);
  // A level Done_Sig has to drop first, otherwise it would also complete the next command.
  assign gap_done  = (gap_cnt >= GAP_END) && !Done_Sig;
  assign last_idx  = (Img_Idx == LAST_IDX);

`ifdef VERIFY_EN
  logic [DATA_W-1:0] exp_data;
  logic              load_err_q;
  logic [IDX_W-1:0]  err_idx_q;
  assign Load_Err = load_err_q;
  assign Err_Idx  = err_idx_q;
`else
  logic unused_rd;
  assign unused_rd = ^RdData;
  assign Load_Err  = 1'b0;
  assign Err_Idx   = '0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      go_q       <= 1'b0;
      fetch_wait <= 1'b0;
      gap_cnt    <= '0;
      Img_Idx    <= '0;
      Start_Sig  <= 2'b00;
      Addr_Sig   <= '0;
      WrData     <= '0;
      Busy       <= 1'b0;
      IICING     <= 1'b0;
      Core_EN    <= 1'b0;
`ifdef VERIFY_EN
      load_err_q <= 1'b0;
      err_idx_q  <= '0;
`endif
    end else begin
      go_q <= Go;
      if (start_req) begin
        state      <= W_FETCH;
        fetch_wait <= 1'b1;
        Img_Idx    <= '0;
        Busy       <= 1'b1;
        IICING     <= 1'b1;
        Core_EN    <= 1'b0;
`ifdef VERIFY_EN
        load_err_q <= 1'b0;
        err_idx_q  <= '0;
`endif
      end else begin
        case (state)
          // The table ROM answers one cycle after the index, so each fetch waits a cycle.
          W_FETCH: begin
            if (fetch_wait) begin
              fetch_wait <= 1'b0;
            end else begin
              Addr_Sig  <= Img_Addr;
              WrData    <= Img_Data;
              Start_Sig <= 2'b01;
              state     <= W_REQ;
            end
          end
          W_REQ: begin
            if (Done_Sig) begin
              Start_Sig <= 2'b00;
              gap_cnt   <= '0;
              state     <= W_GAP;
            end
          end
          W_GAP: begin
            if (!gap_done) begin
              if (gap_cnt < GAP_END) gap_cnt <= gap_cnt + GAP_W'(1);
            end else if (last_idx) begin
              Img_Idx <= '0;
`ifdef VERIFY_EN
              fetch_wait <= 1'b1;
              state      <= R_FETCH;
`else
              Busy    <= 1'b0;
              IICING  <= 1'b0;
              Core_EN <= 1'b1;
              state   <= DONE;
`endif
            end else begin
              Img_Idx    <= Img_Idx + IDX_W'(1);
              fetch_wait <= 1'b1;
              state      <= W_FETCH;
            end
          end
`ifdef VERIFY_EN
          R_FETCH: begin
            if (fetch_wait) begin
              fetch_wait <= 1'b0;
            end else begin
              Addr_Sig  <= Img_Addr;
              exp_data  <= Img_Data;
              Start_Sig <= 2'b10;
              state     <= R_REQ;
            end
          end
          R_REQ: begin
            if (Done_Sig) begin
              Start_Sig <= 2'b00;
              gap_cnt   <= '0;
              if (RdData != exp_data) begin
                load_err_q <= 1'b1;
                err_idx_q  <= Img_Idx;
                Busy       <= 1'b0;
                state      <= ERR;
              end else begin
                state <= R_GAP;
              end
            end
          end
          R_GAP: begin
            if (!gap_done) begin
              if (gap_cnt < GAP_END) gap_cnt <= gap_cnt + GAP_W'(1);
            end else if (last_idx) begin
              Img_Idx <= '0;
              Busy    <= 1'b0;
              IICING  <= 1'b0;
              Core_EN <= 1'b1;
              state   <= DONE;
            end else begin
              Img_Idx    <= Img_Idx + IDX_W'(1);
              fetch_wait <= 1'b1;
              state      <= R_FETCH;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
